// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sharing of the single L2 port between the
// L1 I-cache and L1 D-cache miss interfaces.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_read/i_address              I-cache line read request (held until i_resp)
//   i_rdata/i_resp                line data and 1-cycle completion to I-cache
//   d_read/d_write/d_address      D-cache read or writeback request (held until d_resp)
//   d_wdata                       D-cache writeback line
//   d_rdata/d_resp                line data and 1-cycle completion to D-cache
//   l2_read/l2_write/l2_address   request to L2
//   l2_wdata                      write line to L2
//   l2_rdata/l2_resp              L2 read line and completion
module l2_arbiter #(
  parameter int s_offset = 5,
  parameter int s_addr   = 32,
  parameter int s_line   = 8 * (2 ** s_offset)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [s_addr-1:0] i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } state_e;

  state_e state_q, state_d;
  // 0 = I-cache was granted last, 1 = D-cache
  logic   last_grant_q, last_grant_d;

  logic i_pend;
  logic d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_pend && d_pend) begin
          // tie: the side that did not win last time goes next
          if (last_grant_q) begin
            state_d      = GRANT_I;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GRANT_D;
            last_grant_d = 1'b1;
          end
        end else if (i_pend) begin
          state_d      = GRANT_I;
          last_grant_d = 1'b0;
        end else if (d_pend) begin
          state_d      = GRANT_D;
          last_grant_d = 1'b1;
        end
      end
      GRANT_I: begin
        if (l2_resp) state_d = RELEASE;
      end
      GRANT_D: begin
        if (l2_resp) state_d = RELEASE;
      end
      RELEASE: begin
        // one quiet cycle so the finished requester can drop its request
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Port muxing is decoded from the registered state only.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    unique case (state_q)
      GRANT_I: begin
        l2_read    = 1'b1;
        l2_address = i_address;
        i_resp     = l2_resp;
        i_rdata    = l2_resp ? l2_rdata : '0;
      end
      GRANT_D: begin
        l2_address = d_address;
        l2_wdata   = d_wdata;
        // an illegal read+write collapses to a write
        l2_write   = d_write;
        l2_read    = ~d_write;
        d_resp     = l2_resp;
        d_rdata    = l2_resp ? l2_rdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $error("l2_arbiter: d_read and d_write both high");
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed cases plus randomized traffic checked each
// cycle against a transaction-level model of the shared L2 port.
module tb_l2_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata = '0;
  logic          l2_resp = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  l2_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_address(l2_address),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_resp   (l2_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 30)
        $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: who currently owns the port (0 none, 1 I, 2 D), whether the
  // port is in its mandatory quiet cycle, and who won the last grant.
  int m_owner   = 0;
  bit m_quiet   = 1'b0;
  bit m_last_d  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner  = 0;
      m_quiet  = 1'b0;
      m_last_d = 1'b0;
    end else if (m_owner != 0) begin
      if (l2_resp) begin
        m_owner = 0;
        m_quiet = 1'b1;
      end
    end else if (m_quiet) begin
      m_quiet = 1'b0;
    end else begin
      bit ip;
      bit dp;
      ip = i_read;
      dp = d_read | d_write;
      if (ip && dp) m_owner = m_last_d ? 1 : 2;
      else if (ip) m_owner = 1;
      else if (dp) m_owner = 2;
      if (m_owner != 0) m_last_d = (m_owner == 2);
    end
  end

  always @(negedge clk) begin
    logic          e_rd;
    logic          e_wr;
    logic [AW-1:0] e_ad;
    logic          e_ir;
    logic          e_dr;
    e_rd = (m_owner == 1) || (m_owner == 2 && !d_write);
    e_wr = (m_owner == 2) && d_write;
    e_ad = (m_owner == 1) ? i_address :
           (m_owner == 2) ? d_address : '0;
    e_ir = (m_owner == 1) && l2_resp;
    e_dr = (m_owner == 2) && l2_resp;
    chk("m_l2_read", LW'(l2_read), LW'(e_rd));
    chk("m_l2_write", LW'(l2_write), LW'(e_wr));
    chk("m_l2_addr", LW'(l2_address), LW'(e_ad));
    chk("m_i_resp", LW'(i_resp), LW'(e_ir));
    chk("m_d_resp", LW'(d_resp), LW'(e_dr));
    if (m_owner == 0) chk("m_l2_wdata", l2_wdata, '0);
    if (m_owner == 2) chk("m_l2_wdata", l2_wdata, d_wdata);
    if (e_ir) chk("m_i_rdata", i_rdata, l2_rdata);
    if (e_dr) chk("m_d_rdata", d_rdata, l2_rdata);
    if (m_owner == 0) begin
      chk("m_i_rdata0", i_rdata, '0);
      chk("m_d_rdata0", d_rdata, '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the port request, answers after lat cycles of request,
  // and reports which side saw the response and the data it got.
  task automatic serve(input int lat, input logic [LW-1:0] data,
                       output logic [1:0] who,
                       output logic [LW-1:0] rd);
    int k;
    who = 2'b00;
    rd  = '0;
    for (k = 0; k < 10; k++) begin
      if (l2_read || l2_write) break;
      tick();
    end
    if (k == 10) begin
      chk("serve_timeout", LW'(k), LW'(0));
    end else begin
      for (int j = 1; j < lat; j++) tick();
      l2_resp  = 1'b1;
      l2_rdata = data;
      #1;
      who = {i_resp, d_resp};
      rd  = i_resp ? i_rdata : d_rdata;
      tick();
      l2_resp  = 1'b0;
      l2_rdata = '0;
    end
  endtask

  initial begin
    logic [1:0]    who;
    logic [LW-1:0] rd;
    logic [LW-1:0] wd;
    logic [1:0]    order [4];
    int            cnt;
    logic          n_ir, n_dr, n_dw, n_resp;
    logic [AW-1:0] n_ia, n_da;
    logic [LW-1:0] n_wd, n_rdat;

    tick();
    tick();
    chk("rst_l2_read", LW'(l2_read), '0);
    chk("rst_l2_write", LW'(l2_write), '0);
    chk("rst_l2_addr", LW'(l2_address), '0);
    chk("rst_l2_wdata", l2_wdata, '0);
    chk("rst_resp", LW'({i_resp, d_resp}), '0);
    rst = 1'b0;
    tick();

    // 1: I-cache read, 3-cycle L2 latency
    i_address = 32'h0000_1000;
    i_read    = 1'b1;
    tick();
    chk("t1_l2_read", LW'(l2_read), LW'(1));
    chk("t1_l2_addr", LW'(l2_address), LW'(32'h1000));
    serve(3, {32{8'hA5}}, who, rd);
    chk("t1_who", LW'(who), LW'(2'b10));
    chk("t1_rdata", rd, {32{8'hA5}});
    i_read = 1'b0;
    chk("t1_release", LW'({l2_read, l2_write}), '0);
    tick();

    // 2: D-cache writeback
    wd        = {8{32'h1234_5678}};
    d_address = 32'h0000_2040;
    d_wdata   = wd;
    d_write   = 1'b1;
    tick();
    chk("t2_l2_write", LW'({l2_write, l2_read}), LW'(2'b10));
    chk("t2_l2_addr", LW'(l2_address), LW'(32'h2040));
    chk("t2_l2_wdata", l2_wdata, wd);
    serve(2, rnd_line(), who, rd);
    chk("t2_who", LW'(who), LW'(2'b01));
    d_write = 1'b0;
    tick();

    // 3: simultaneous requests after reset, held high
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    i_address = 32'h0000_3000;
    d_address = 32'h0000_4000;
    i_read    = 1'b1;
    d_read    = 1'b1;
    for (int t = 0; t < 4; t++) begin
      serve(1, rnd_line(), who, rd);
      order[t] = who;
    end
    i_read = 1'b0;
    d_read = 1'b0;
    chk("t3_g0", LW'(order[0]), LW'(2'b01));
    chk("t3_g1", LW'(order[1]), LW'(2'b10));
    chk("t3_g2", LW'(order[2]), LW'(2'b01));
    chk("t3_g3", LW'(order[3]), LW'(2'b10));
    tick();
    tick();

    // 4: stray L2 response with the port idle
    l2_resp = 1'b1;
    #1;
    chk("t4_resp", LW'({i_resp, d_resp}), '0);
    tick();
    l2_resp = 1'b0;
    tick();
    chk("t4_idle", LW'({l2_read, l2_write}), '0);
    i_read = 1'b1;
    tick();
    chk("t4_grant", LW'(l2_read), LW'(1));
    serve(2, rnd_line(), who, rd);
    chk("t4_who", LW'(who), LW'(2'b10));
    i_read = 1'b0;
    tick();

    // 5: reset two cycles into a D grant
    d_address = 32'h0000_5000;
    d_wdata   = rnd_line();
    d_write   = 1'b1;
    tick();
    tick();
    chk("t5_granted", LW'(l2_write), LW'(1));
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    d_write = 1'b0;
    #1;
    chk("t5_rst_rw", LW'({l2_read, l2_write}), '0);
    chk("t5_rst_addr", LW'(l2_address), '0);
    chk("t5_rst_wdata", l2_wdata, '0);
    i_address = 32'h0000_6000;
    i_read    = 1'b1;
    wd        = rnd_line();
    serve(1, wd, who, rd);
    chk("t5_who", LW'(who), LW'(2'b10));
    chk("t5_rdata", rd, wd);
    i_read = 1'b0;
    tick();

    // random traffic
    cnt = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_ir = i_read;
      n_ia = i_address;
      n_dr = d_read;
      n_dw = d_write;
      n_da = d_address;
      n_wd = d_wdata;
      n_rdat = l2_rdata;
      if (i_resp) n_ir = 1'b0;
      else if (!i_read && $urandom_range(0, 3) == 0) begin
        n_ir = 1'b1;
        n_ia = $urandom;
      end else if (i_read && $urandom_range(0, 63) == 0) n_ir = 1'b0;
      if (d_resp) begin
        n_dr = 1'b0;
        n_dw = 1'b0;
      end else if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) n_dw = 1'b1;
        else n_dr = 1'b1;
        n_da = $urandom;
        n_wd = rnd_line();
      end
      if (l2_resp) n_resp = 1'b0;
      else if (l2_read || l2_write) begin
        if (cnt < 0) cnt = $urandom_range(0, 3);
        if (cnt == 0) begin
          n_resp = 1'b1;
          n_rdat = rnd_line();
          cnt    = -1;
        end else begin
          n_resp = 1'b0;
          cnt--;
        end
      end else begin
        n_resp = !i_read && !d_read && !d_write &&
                 ($urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      #1;
      i_read    = n_ir;
      i_address = n_ia;
      d_read    = n_dr;
      d_write   = n_dw;
      d_address = n_da;
      d_wdata   = n_wd;
      l2_resp   = n_resp;
      l2_rdata  = n_rdat;
    end
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    l2_resp = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
